traffic_lamp_driver: RTL and testbench
======================================

# traffic_lamp_driver

Parametrised lamp driver for N signalised approaches. It turns per-approach colour commands from the sequencer into registered red/yellow/green lamp outputs. On top of plain decoding it adds an all-red emergency override, a night flashing mode and a latched conflict/invalid-command safety fault with flashing all-red. It sits between the phase sequencer and the LED pins and supersedes the fixed two-approach driver.

## Interface
- N_DIR, 2, number of approaches (2..8).
- ACTIVE_LOW, 0, 1 inverts every led_output bit at the pin.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2).
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- phase_cmd  in  2*N_DIR  per-approach colour code; approach i at bits [2i+1:2i]. Codes: 00 red, 01 green, 10 yellow, 11 invalid.
- cmd_valid  in  1  phase_cmd sampled this cycle.
- emerg_active  in  1  force solid all-red.
- flash_mode  in  1  night flashing.
- fault_clr  in  1  clear a latched fault.
- led_output  out  3*N_DIR  lamps. Approach i is at bits [3(N_DIR-i)-1 -: 3], ordered {R,Y,G}, with approach 0 in the MSBs.
- fault  out  1  safety fault latched.
- fault_code  out  2  01 conflict, 10 invalid code, 00 none.
- mode  out  2  00 NORMAL, 01 EMERG, 10 FLASH, 11 FAULT.

## Operation
- **Mode selection**, evaluated each cycle in priority order:
  1. rst.
  2. Fault latched → FAULT.
  3. emerg_active → EMERG.
  4. flash_mode → FLASH.
  5. Otherwise NORMAL.
- **NORMAL:** a command loads the lamp register only when cmd_valid=1 and the command passes both checks. Otherwise the lamp register holds.
- **Conflict check:** more than one approach coded 01 or 10 → fault_code 01.
- **Invalid check:** any approach coded 11 → fault_code 10. If both conditions hold, conflict (01) wins.
- **Command that fails a check:** it is discarded, fault sets and mode goes to FAULT. Detection runs only in NORMAL; in every other mode cmd_valid is ignored.
- **EMERG:** all approaches solid red (100 each).
- **FLASH:**
  - blink on: approach 0 yellow (010), all others red (100).
  - blink off: all lamps 000.
- **FAULT:** all approaches red when blink on, 000 when blink off.
- **Fault clear:** fault_clr=1 in FAULT clears fault and fault_code.
  - Mode re-evaluates next cycle.
  - The lamp register is all-red on exit.
- **Lamp register forcing:** the lamp register is forced to all-red whenever mode ≠ NORMAL. On return to NORMAL the lamps stay all-red until the next accepted command.
- **Blink generator:**
  - Counter runs 0..BLINK_DIV-1; blink phase toggles on wrap.
  - Counter and phase reset to 0 / on whenever mode enters FLASH or FAULT, so the first on-period is a full BLINK_DIV cycles.
  - It free-runs otherwise; its value is irrelevant outside FLASH and FAULT.
- **Polarity:** ACTIVE_LOW applies only at the output register: led_output = ~pattern.

## Timing
- Reset values:
  - led_output = all-red (100 per approach), inverted if ACTIVE_LOW.
  - fault=0, fault_code=00, mode=00.
  - Blink counter=0, blink phase on.
- All outputs are registered.
- Inputs sampled at edge k appear on outputs after edge k (1-cycle latency). This applies to commands, emerg_active, flash_mode, fault detection and fault_clr alike.
- Fault set and all-red-on output occur at the same edge that samples the offending command.
- Simultaneous events:
  - fault_clr while emerg_active=1 → clears, then EMERG.
  - fault_clr and a new bad command in the same cycle → the command is ignored, because the mode is not NORMAL.
  - rst overrides everything.
- Reset asserted mid-blink or mid-fault returns to all reset values on the next edge.
- Blink toggles every BLINK_DIV cycles; the full period is 2·BLINK_DIV.

## Test plan
All scenarios use N_DIR=2, BLINK_DIV=4, ACTIVE_LOW=0 unless stated.
- **Reset:** rst for 2 cycles → led_output=100100, fault=0, mode=00.
- **Normal command:** phase_cmd=0001, cmd_valid=1 → next cycle led_output=001100. Then 0010 → 010100. Then 0100 → 100001. Holds when cmd_valid=0.
- **Conflict fault:** phase_cmd=0101, cmd_valid=1 → fault=1, fault_code=01, mode=11. led_output is 100100 for 4 cycles, then 000000 for 4, repeating. Later commands are ignored. fault_clr → next cycle fault=0, mode=00, led_output=100100.
- **Invalid fault:** phase_cmd=1100 → fault_code=10, mode=11.
- **Flash and emergency:**
  - flash_mode=1 → 010100 for 4 cycles, then 000000 for 4.
  - emerg_active=1 mid-flash → next cycle 100100, mode=01.
  - Release both → 100100 until the next command.
- **ACTIVE_LOW=1:** reset → led_output=011011. Command 0001 → 110011.

Source files
------------

// File: rtl/traffic_lamp_driver.sv
// Lamp driver for N_DIR signalised approaches: decodes sequencer colour codes into
// registered R/Y/G lamps, with emergency all-red, night flashing and a latched safety fault.
module traffic_lamp_driver #(
    parameter int N_DIR      = 2,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*N_DIR-1:0]   phase_cmd,
    input  logic                 cmd_valid,
    input  logic                 emerg_active,
    input  logic                 flash_mode,
    input  logic                 fault_clr,
    output logic [3*N_DIR-1:0]   led_output,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [1:0]           mode
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_EMERG  = 2'b01,
        MODE_FLASH  = 2'b10,
        MODE_FAULT  = 2'b11
    } mode_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_INVALID  = 2'b10;

    mode_t                mode_reg, mode_next, mode_eff;
    logic                 fault_reg, fault_next;
    logic [1:0]           fault_code_reg, fault_code_next;
    logic [3*N_DIR-1:0]   lamp_reg, lamp_next;
    logic [3*N_DIR-1:0]   led_output_reg, led_output_next;
    logic [CW-1:0]        blink_cnt_reg, blink_cnt_next;
    logic                 blink_on_reg, blink_on_next;

    logic [N_DIR-1:0]     active_vec;
    logic [N_DIR-1:0]     invalid_vec;
    logic [3*N_DIR-1:0]   decoded;
    logic [3*N_DIR-1:0]   all_red;
    logic [3*N_DIR-1:0]   flash_on;
    logic                 conflict;
    logic                 invalid;
    logic                 blink_enter;
    logic [3*N_DIR-1:0]   pattern;

    // Per-approach decode; approach 0 occupies the most significant lamp triplet.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIR; gi++) begin : g_dir
            logic [1:0] code;
            assign code            = phase_cmd[2*gi+1 -: 2];
            assign active_vec[gi]  = (code == 2'b01) || (code == 2'b10);
            assign invalid_vec[gi] = (code == 2'b11);
            assign decoded[3*(N_DIR-gi)-1 -: 3]  = (code == 2'b01) ? 3'b001 :
                                                   (code == 2'b10) ? 3'b010 : 3'b100;
            assign all_red[3*(N_DIR-gi)-1 -: 3]  = 3'b100;
            assign flash_on[3*(N_DIR-gi)-1 -: 3] = (gi == 0) ? 3'b010 : 3'b100;
        end
    endgenerate

    // More than one bit set means two approaches are showing a go/caution colour.
    assign conflict = (active_vec & (active_vec - 1'b1)) != '0;
    assign invalid  = |invalid_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg       <= MODE_NORMAL;
            fault_reg      <= 1'b0;
            fault_code_reg <= CODE_NONE;
            lamp_reg       <= all_red;
            led_output_reg <= ACTIVE_LOW ? ~all_red : all_red;
            blink_cnt_reg  <= '0;
            blink_on_reg   <= 1'b1;
        end else begin
            mode_reg       <= mode_next;
            fault_reg      <= fault_next;
            fault_code_reg <= fault_code_next;
            lamp_reg       <= lamp_next;
            led_output_reg <= led_output_next;
            blink_cnt_reg  <= blink_cnt_next;
            blink_on_reg   <= blink_on_next;
        end
    end

    always_comb begin
        mode_eff        = fault_reg    ? MODE_FAULT :
                          emerg_active ? MODE_EMERG :
                          flash_mode   ? MODE_FLASH : MODE_NORMAL;
        mode_next       = mode_eff;
        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;
        lamp_next       = lamp_reg;
        case (mode_eff)
            MODE_NORMAL: begin
                if (cmd_valid) begin
                    if (conflict) begin
                        fault_next      = 1'b1;
                        fault_code_next = CODE_CONFLICT;
                        mode_next       = MODE_FAULT;
                    end else if (invalid) begin
                        fault_next      = 1'b1;
                        fault_code_next = CODE_INVALID;
                        mode_next       = MODE_FAULT;
                    end else begin
                        lamp_next = decoded;
                    end
                end
            end
            MODE_FAULT: begin
                if (fault_clr) begin
                    fault_next      = 1'b0;
                    fault_code_next = CODE_NONE;
                    mode_next       = emerg_active ? MODE_EMERG :
                                      flash_mode   ? MODE_FLASH : MODE_NORMAL;
                end
            end
            default: ;
        endcase
        if (mode_next != MODE_NORMAL) begin
            lamp_next = all_red;
        end

        // A fresh entry into a blinking mode restarts with a full on-period.
        blink_enter    = ((mode_next == MODE_FLASH) || (mode_next == MODE_FAULT)) &&
                         (mode_next != mode_reg);
        blink_cnt_next = blink_cnt_reg + CW'(1);
        blink_on_next  = blink_on_reg;
        if (blink_enter) begin
            blink_cnt_next = '0;
            blink_on_next  = 1'b1;
        end else if (blink_cnt_reg == CW'(BLINK_DIV - 1)) begin
            blink_cnt_next = '0;
            blink_on_next  = ~blink_on_reg;
        end
    end

    always_comb begin
        pattern = all_red;
        case (mode_next)
            MODE_NORMAL: pattern = lamp_next;
            MODE_EMERG:  pattern = all_red;
            MODE_FLASH:  pattern = blink_on_next ? flash_on : '0;
            MODE_FAULT:  pattern = blink_on_next ? all_red : '0;
            default:     pattern = all_red;
        endcase
        led_output_next = ACTIVE_LOW ? ~pattern : pattern;
    end

    assign led_output = led_output_reg;
    assign fault      = fault_reg;
    assign fault_code = fault_code_reg;
    assign mode       = mode_reg;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver (N_DIR=2, BLINK_DIV=4); an ACTIVE_LOW copy shares the stimulus.
module tb_traffic_lamp_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] phase_cmd;
    logic       cmd_valid;
    logic       emerg_active;
    logic       flash_mode;
    logic       fault_clr;
    logic [5:0] led_output;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] mode;
    logic [5:0] led_output_low;
    logic       fault_low;
    logic [1:0] fault_code_low;
    logic [1:0] mode_low;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    traffic_lamp_driver #(.N_DIR(2), .ACTIVE_LOW(1'b0), .BLINK_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .phase_cmd    (phase_cmd),
        .cmd_valid    (cmd_valid),
        .emerg_active (emerg_active),
        .flash_mode   (flash_mode),
        .fault_clr    (fault_clr),
        .led_output   (led_output),
        .fault        (fault),
        .fault_code   (fault_code),
        .mode         (mode)
    );

    traffic_lamp_driver #(.N_DIR(2), .ACTIVE_LOW(1'b1), .BLINK_DIV(4)) dut_low (
        .clk          (clk),
        .rst          (rst),
        .phase_cmd    (phase_cmd),
        .cmd_valid    (cmd_valid),
        .emerg_active (emerg_active),
        .flash_mode   (flash_mode),
        .fault_clr    (fault_clr),
        .led_output   (led_output_low),
        .fault        (fault_low),
        .fault_code   (fault_code_low),
        .mode         (mode_low)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0b expected %0b", tag, actual, expected);
        end else begin
            $display("[TB] ok   %s: %0b", tag, actual);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; phase_cmd = 4'b0000; cmd_valid = 1'b0;
        emerg_active = 1'b0; flash_mode = 1'b0; fault_clr = 1'b0;
        step(); step();
        check("reset_led", led_output, 6'b100100);
        check("reset_fault", fault, 1'b0);
        check("reset_code", fault_code, 2'b00);
        check("reset_mode", mode, 2'b00);
        check("reset_led_low", led_output_low, 6'b011011);

        rst = 1'b0;
        phase_cmd = 4'b0001; cmd_valid = 1'b1; step();
        check("cmd_0001", led_output, 6'b001100);
        check("cmd_0001_low", led_output_low, 6'b110011);
        phase_cmd = 4'b0010; step();
        check("cmd_0010", led_output, 6'b010100);
        phase_cmd = 4'b0100; step();
        check("cmd_0100", led_output, 6'b100001);
        phase_cmd = 4'b0001; cmd_valid = 1'b0; step(); step();
        check("hold_no_valid", led_output, 6'b100001);
        check("hold_mode", mode, 2'b00);

        // Conflict: two approaches green; fault flashes all-red 4 on / 4 off.
        phase_cmd = 4'b0101; cmd_valid = 1'b1; step();
        check("conflict_fault", fault, 1'b1);
        check("conflict_code", fault_code, 2'b01);
        check("conflict_mode", mode, 2'b11);
        check("conflict_led0", led_output, 6'b100100);
        phase_cmd = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("fault_blink%0d", i), led_output, (i < 4 || i == 8) ? 6'b100100 : 6'b000000);
        end
        check("fault_ignores_cmd", mode, 2'b11);

        cmd_valid = 1'b0; fault_clr = 1'b1; step();
        fault_clr = 1'b0;
        check("clr_fault", fault, 1'b0);
        check("clr_code", fault_code, 2'b00);
        check("clr_mode", mode, 2'b00);
        check("clr_led", led_output, 6'b100100);
        step();
        check("after_clr_red", led_output, 6'b100100);

        phase_cmd = 4'b1100; cmd_valid = 1'b1; step();
        cmd_valid = 1'b0;
        check("invalid_code", fault_code, 2'b10);
        check("invalid_mode", mode, 2'b11);

        // Clear while emergency is held: clears, then EMERG.
        fault_clr = 1'b1; emerg_active = 1'b1; step();
        fault_clr = 1'b0;
        check("clr_emerg_fault", fault, 1'b0);
        check("clr_emerg_mode", mode, 2'b01);
        check("clr_emerg_led", led_output, 6'b100100);
        emerg_active = 1'b0; step();
        check("emerg_release_mode", mode, 2'b00);

        // Flash: approach 0 yellow 4 cycles, dark 4; a bad command is ignored.
        flash_mode = 1'b1; step();
        check("flash_mode", mode, 2'b10);
        check("flash_led0", led_output, 6'b010100);
        phase_cmd = 4'b0101; cmd_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("flash_blink%0d", i), led_output, (i < 4 || i == 8) ? 6'b010100 : 6'b000000);
        end
        check("flash_no_fault", fault, 1'b0);

        emerg_active = 1'b1; step();
        check("emerg_mode", mode, 2'b01);
        check("emerg_led", led_output, 6'b100100);
        emerg_active = 1'b0; flash_mode = 1'b0; cmd_valid = 1'b0; step();
        check("release_mode", mode, 2'b00);
        check("release_led", led_output, 6'b100100);
        step();
        check("release_hold", led_output, 6'b100100);
        phase_cmd = 4'b0010; cmd_valid = 1'b1; step();
        cmd_valid = 1'b0;
        check("post_release_cmd", led_output, 6'b010100);

        // Reset in the middle of a fault.
        phase_cmd = 4'b1010; cmd_valid = 1'b1; step();
        cmd_valid = 1'b0; step();
        check("pre_rst_fault", fault, 1'b1);
        rst = 1'b1; step();
        rst = 1'b0;
        check("rst_mid_fault", fault, 1'b0);
        check("rst_mid_mode", mode, 2'b00);
        check("rst_mid_code", fault_code, 2'b00);
        check("rst_mid_led", led_output, 6'b100100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
